// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - op codes and helpers shared by the multi-mode shift register
//
// Purpose: single source for the operation encoding used by shift_reg_n and its
// combinational step function, plus a classifier for the shift class.
package shift_reg_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_HOLD  = 3'b000;
  localparam op_t OP_LOAD  = 3'b001;
  localparam op_t OP_SHL   = 3'b010;
  localparam op_t OP_SHR   = 3'b011;
  localparam op_t OP_ASR   = 3'b100;
  localparam op_t OP_ROL   = 3'b101;
  localparam op_t OP_ROR   = 3'b110;
  localparam op_t OP_CLEAR = 3'b111;

  // Shift class: the only ops that may be repeated by a counted run.
  function automatic logic is_shift(input op_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_reg_n_step.sv
// rtl/shift_reg_n_step.sv - combinational next-value function of the shift register
//
// Purpose: computes the register value after one application of an op.
// Ports:
//   op_i      operation code
//   q_i       current register value
//   d_i       parallel load data
//   sin_i     serial input bit (SHL/SHR)
//   q_next_o  value after one step of op_i
module shift_reg_n_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (op_i)
      OP_HOLD:  q_next_o = q_i;
      OP_LOAD:  q_next_o = d_i;
      OP_SHL:   q_next_o = {q_i[WIDTH-2:0], sin_i};
      OP_SHR:   q_next_o = {sin_i, q_i[WIDTH-1:1]};
      OP_ASR:   q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      OP_ROL:   q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_ROR:   q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      OP_CLEAR: q_next_o = '0;
      default:  q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - parametrised multi-mode register with counted shift runs
//
// Purpose: hold/load/clear/shift/rotate register; a start pulse with a shift op
// and a non-zero amount runs that shift autonomously amount times.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   op, d, sin     operation, parallel data, serial input
//   start, amount  begin counted run of op, amount steps
//   q              register contents
//   sout_l, sout_r MSB / LSB of q
//   zero           q == 0
//   busy           counted run in progress
//   done           one-cycle completion pulse
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  op_t              op_r_q, op_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_t              step_op;
  logic [WIDTH-1:0] step_q;

  // While a run is active the latched op drives the step; live op is ignored.
  assign step_op = busy_q ? op_r_q : op_t'(op);

  shift_reg_n_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (step_op),
    .q_i      (q_q),
    .d_i      (d),
    .sin_i    (sin),
    .q_next_o (step_q)
  );

  always_comb begin
    q_d    = q_q;
    op_r_d = op_r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      q_d   = step_q;
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      if (is_shift(op_t'(op))) begin
        // q is left untouched on the accepting edge; shifts begin next edge.
        if (amount != '0) begin
          op_r_d = op_t'(op);
          cnt_d  = amount;
          busy_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        q_d    = step_q;
        done_d = 1'b1;
      end
    end else begin
      q_d = step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= '0;
      op_r_q <= OP_HOLD;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      op_r_q <= op_r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign zero   = (q_q == '0);
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// tb/tb_shift_reg_n.sv - self-checking bench for shift_reg_n at WIDTH=8
module tb_shift_reg_n;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] op;
  logic [7:0] d;
  logic       sin;
  logic       start;
  logic [3:0] amount;
  logic [7:0] q;
  logic       sout_l, sout_r, zero, busy, done;

  int checks = 0;
  int errors = 0;

  shift_reg_n #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (op),
    .d       (d),
    .sin     (sin),
    .start   (start),
    .amount  (amount),
    .q       (q),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: value arithmetic plus a count of remaining run steps.
  logic [7:0] m_q    = 8'h00;
  int         m_left = 0;
  logic [2:0] m_op   = 3'b000;
  logic       m_done = 1'b0;

  function automatic logic [7:0] apply(input logic [2:0] o, input logic [7:0] v,
                                       input logic [7:0] dd, input logic s);
    int x;
    x = int'(v);
    case (o)
      3'd1:    x = int'(dd);
      3'd2:    x = ((x * 2) + int'(s)) % 256;
      3'd3:    x = (x / 2) + (int'(s) * 128);
      3'd4:    x = (x / 2) + ((x >= 128) ? 128 : 0);
      3'd5:    x = ((x * 2) % 256) + (x / 128);
      3'd6:    x = (x / 2) + ((x % 2) * 128);
      3'd7:    x = 0;
      default: x = int'(v);
    endcase
    return 8'(x);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q = 8'h00; m_left = 0; m_op = 3'b000; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_q = apply(m_op, m_q, d, sin);
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (start) begin
        if (op >= 3'd2 && op <= 3'd6) begin
          if (amount == 4'd0) m_done = 1'b1;
          else begin
            m_op = op;
            m_left = int'(amount);
          end
        end else begin
          m_q = apply(op, m_q, d, sin);
          m_done = 1'b1;
        end
      end else begin
        m_q = apply(op, m_q, d, sin);
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("q", 32'(q), 32'(m_q));
    check("sout_l", 32'(sout_l), 32'(m_q[7]));
    check("sout_r", 32'(sout_r), 32'(m_q[0]));
    check("zero", 32'(zero), 32'(m_q == 8'h00));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
  end

  task automatic drive(input logic rn, input logic [2:0] o, input logic [7:0] dd,
                       input logic s, input logic st, input logic [3:0] am);
    reset_n = rn; op = o; d = dd; sin = s; start = st; amount = am;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [7:0] exp_q,
                     input logic exp_busy, input logic exp_done);
    check({name, "_q"}, 32'(q), 32'(exp_q));
    check({name, "_model_q"}, 32'(m_q), 32'(exp_q));
    check({name, "_busy"}, 32'(busy), 32'(exp_busy));
    check({name, "_done"}, 32'(done), 32'(exp_done));
  endtask

  int busy_cycles;
  int done_pulses;

  initial begin
    // Reset dominates LOAD/start.
    drive(1'b0, OP_LOAD, 8'hA5, 1'b0, 1'b1, 4'd3);
    pin("reset", 8'h00, 1'b0, 1'b0);
    drive(1'b0, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);

    // Single-step ops.
    drive(1'b1, OP_LOAD, 8'h96, 1'b0, 1'b0, 4'd0);  pin("load96", 8'h96, 1'b0, 1'b0);
    drive(1'b1, OP_ASR, 8'h00, 1'b0, 1'b0, 4'd0);   pin("asr", 8'hCB, 1'b0, 1'b0);
    check("asr_zero", 32'(zero), 32'd0);
    drive(1'b1, OP_SHR, 8'h00, 1'b0, 1'b0, 4'd0);   pin("shr", 8'h65, 1'b0, 1'b0);
    drive(1'b1, OP_SHL, 8'h00, 1'b1, 1'b0, 4'd0);   pin("shl", 8'hCB, 1'b0, 1'b0);
    drive(1'b1, OP_CLEAR, 8'h00, 1'b0, 1'b0, 4'd0); pin("clear", 8'h00, 1'b0, 1'b0);
    check("clear_zero", 32'(zero), 32'd1);

    // Counted ROL x3 on 0x81.
    drive(1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
    drive(1'b1, OP_ROL, 8'h00, 1'b0, 1'b1, 4'd3);   pin("rol_e0", 8'h81, 1'b1, 1'b0);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("rol_e1", 8'h03, 1'b1, 1'b0);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("rol_e2", 8'h06, 1'b1, 1'b0);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("rol_e3", 8'h0C, 1'b0, 1'b1);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("rol_after", 8'h0C, 1'b0, 1'b0);

    // Counted SHR x4 on 0xF0 with LOAD/start driven during busy.
    drive(1'b1, OP_LOAD, 8'hF0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, OP_SHR, 8'h00, 1'b0, 1'b1, 4'd4);
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cycles++;
      drive(1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b1, 4'd2);
      if (done) done_pulses++;
    end
    pin("shr4_end", 8'h0F, 1'b0, 1'b1);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    if (done) done_pulses++;
    check("shr4_busy_cycles", 32'(busy_cycles), 32'd4);
    check("shr4_done_pulses", 32'(done_pulses), 32'd1);

    // amount = 0.
    drive(1'b1, OP_LOAD, 8'h5A, 1'b0, 1'b0, 4'd0);
    drive(1'b1, OP_SHL, 8'h00, 1'b1, 1'b1, 4'd0);   pin("amt0", 8'h5A, 1'b0, 1'b1);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("amt0_after", 8'h5A, 1'b0, 1'b0);

    // start with a non-shift op executes once.
    drive(1'b1, OP_CLEAR, 8'h00, 1'b0, 1'b1, 4'd5); pin("start_clear", 8'h00, 1'b0, 1'b1);

    // amount > WIDTH: ROR x9 on 0x81 equals ROR x1.
    drive(1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
    drive(1'b1, OP_ROR, 8'h00, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 9; i++) drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    pin("ror9", 8'hC0, 1'b0, 1'b1);

    // Reset mid-run.
    drive(1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b0, 4'd0);
    drive(1'b1, OP_SHL, 8'h00, 1'b0, 1'b1, 4'd5);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("abort_e1", 8'hFE, 1'b1, 1'b0);
    drive(1'b0, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("abort_rst", 8'h00, 1'b0, 1'b0);
    drive(1'b1, OP_LOAD, 8'h3C, 1'b0, 1'b0, 4'd0);  pin("abort_load", 8'h3C, 1'b0, 1'b0);
    drive(1'b1, OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);  pin("abort_idle", 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
